sbox_seq_ctrl: RTL

//  Time-multiplexes one shared S-box lookup port across all eight DES S-boxes for
//  the DES f-function. Accepts a 48-bit word (E-expansion XOR subkey) over valid/ready.

---
 rtl/sbox_seq_ctrl.sv | 112 +++++++++++
 1 files changed

// File: rtl/sbox_seq_ctrl.sv
// Shares one S-box lookup port across the eight DES S-boxes, one lookup per cycle.
// Takes 8 cycles from accept to out_valid; accepts new input only in IDLE and holds the result until out_ready.
module sbox_seq_ctrl #(
  parameter int NUM_BOX = 8,
  parameter int IN_W    = 6,
  parameter int OUT_W   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [NUM_BOX*IN_W-1:0]  in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [2:0]               sbox_sel,
  output logic [IN_W-1:0]          sbox_in,
  output logic                     sbox_en,
  input  logic [OUT_W-1:0]         sbox_out,
  output logic [NUM_BOX*OUT_W-1:0] out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy
);

  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                   state;
  logic [CNT_W-1:0]         cnt;
  logic [NUM_BOX*IN_W-1:0]  data;
  logic [NUM_BOX*OUT_W-1:0] result;
  logic [IN_W-1:0]          chunk;

  // cnt is zero in every state except RUN, so it drives sbox_sel directly.
  assign sbox_sel = cnt;
  assign sbox_in  = sbox_en ? chunk : '0;
  assign out_data = result;

  // S1 takes the most significant field of the latched word.
  always_comb begin
    chunk = '0;
    for (int i = 0; i < NUM_BOX; i++) begin
      if (cnt == CNT_W'(i)) chunk = data[(NUM_BOX-1-i)*IN_W +: IN_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      data      <= '0;
      result    <= '0;
      in_ready  <= 1'b1;
      sbox_en   <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      cnt       <= '0;
      in_ready  <= 1'b1;
      sbox_en   <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            data     <= in_data;
            cnt      <= '0;
            result   <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            sbox_en  <= 1'b1;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          for (int i = 0; i < NUM_BOX; i++) begin
            if (cnt == CNT_W'(i)) result[(NUM_BOX-1-i)*OUT_W +: OUT_W] <= sbox_out;
          end
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(NUM_BOX-1)) begin
            state     <= DONE;
            sbox_en   <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          in_ready  <= 1'b1;
          sbox_en   <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
